// File: rtl/modulo_transmisor_hamming_if.sv
// Nibble + error-mask handshake bundle for the Hamming (8,4) transmitter.
// The source drives data/mask/valid; the transmitter answers with ready.
interface modulo_transmisor_hamming_if;
  logic [3:0] datos_in;
  logic       valido_in;
  logic       listo_out;
  logic [7:0] mascara_error;

  modport master (
    output datos_in,
    output valido_in,
    output mascara_error,
    input  listo_out
  );

  modport slave (
    input  datos_in,
    input  valido_in,
    input  mascara_error,
    output listo_out
  );
endinterface

// File: rtl/modulo_transmisor_hamming.sv
// Hamming SECDED (8,4) encoder with error injection and a serial
// start/8-data/stop framer; all outputs are registered.
module modulo_transmisor_hamming #(
  parameter int unsigned CICLOS_POR_BIT = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  modulo_transmisor_hamming_if.slave   bus,
  output logic [7:0]                   palabra_codificada,
  output logic [7:0]                   palabra_enviada,
  output logic                         tx_serial,
  output logic                         tx_activo,
  output logic                         trama_fin
);

  typedef enum logic [1:0] {
    REPOSO,
    INICIO,
    DATOS,
    PARADA
  } estado_t;

  localparam logic [7:0] ULTIMO = 8'(CICLOS_POR_BIT - 1);

  function automatic logic [7:0] codificar(input logic [3:0] d);
    logic [7:0] w;
    w[0] = d[0] ^ d[1] ^ d[3];
    w[1] = d[0] ^ d[2] ^ d[3];
    w[2] = d[0];
    w[3] = d[1] ^ d[2] ^ d[3];
    w[4] = d[1];
    w[5] = d[2];
    w[6] = d[3];
    w[7] = ^w[6:0];
    return w;
  endfunction

  estado_t    estado_q, estado_n;
  logic [7:0] cnt_q, cnt_n;
  logic [2:0] idx_q, idx_n;
  logic [7:0] cod_n, env_n;
  logic       tx_n, activo_n, fin_n, listo_q, listo_n;
  logic       ultimo;

  assign bus.listo_out = listo_q;
  assign ultimo = (cnt_q == ULTIMO);

  always_comb begin
    estado_n = estado_q;
    cnt_n    = cnt_q;
    idx_n    = idx_q;
    cod_n    = palabra_codificada;
    env_n    = palabra_enviada;
    tx_n     = tx_serial;
    activo_n = tx_activo;
    listo_n  = listo_q;
    fin_n    = 1'b0;
    unique case (estado_q)
      REPOSO: begin
        if (bus.valido_in) begin
          estado_n = INICIO;
          cnt_n    = 8'd0;
          cod_n    = codificar(bus.datos_in);
          env_n    = cod_n ^ bus.mascara_error;
          tx_n     = 1'b0;
          activo_n = 1'b1;
          listo_n  = 1'b0;
        end
      end
      INICIO: begin
        if (ultimo) begin
          estado_n = DATOS;
          cnt_n    = 8'd0;
          idx_n    = 3'd0;
          tx_n     = palabra_enviada[0];
        end else begin
          cnt_n = cnt_q + 8'd1;
        end
      end
      DATOS: begin
        if (!ultimo) begin
          cnt_n = cnt_q + 8'd1;
        end else if (idx_q == 3'd7) begin
          estado_n = PARADA;
          cnt_n    = 8'd0;
          tx_n     = 1'b1;
        end else begin
          cnt_n = 8'd0;
          idx_n = idx_q + 3'd1;
          tx_n  = palabra_enviada[idx_n];
        end
      end
      PARADA: begin
        if (ultimo) begin
          estado_n = REPOSO;
          cnt_n    = 8'd0;
          activo_n = 1'b0;
          listo_n  = 1'b1;
          fin_n    = 1'b1;
        end else begin
          cnt_n = cnt_q + 8'd1;
        end
      end
      default: estado_n = REPOSO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q           <= REPOSO;
      cnt_q              <= 8'd0;
      idx_q              <= 3'd0;
      palabra_codificada <= 8'h00;
      palabra_enviada    <= 8'h00;
      tx_serial          <= 1'b1;
      tx_activo          <= 1'b0;
      trama_fin          <= 1'b0;
      listo_q            <= 1'b1;
    end else begin
      estado_q           <= estado_n;
      cnt_q              <= cnt_n;
      idx_q              <= idx_n;
      palabra_codificada <= cod_n;
      palabra_enviada    <= env_n;
      tx_serial          <= tx_n;
      tx_activo          <= activo_n;
      trama_fin          <= fin_n;
      listo_q            <= listo_n;
    end
  end

endmodule

// File: tb/tb_modulo_transmisor_hamming.sv
// Directed bench for the Hamming (8,4) transmitter: encoding, framing,
// error injection, back-to-back frames, mid-frame reset, 1 cycle/bit.
module tb_modulo_transmisor_hamming;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  modulo_transmisor_hamming_if bus0 ();
  modulo_transmisor_hamming_if bus1 ();

  logic [7:0] cod0, env0, cod1, env1;
  logic       tx0, act0, fin0, tx1, act1, fin1;

  modulo_transmisor_hamming #(.CICLOS_POR_BIT(4)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave),
    .palabra_codificada(cod0), .palabra_enviada(env0),
    .tx_serial(tx0), .tx_activo(act0), .trama_fin(fin0)
  );

  modulo_transmisor_hamming #(.CICLOS_POR_BIT(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave),
    .palabra_codificada(cod1), .palabra_enviada(env1),
    .tx_serial(tx1), .tx_activo(act1), .trama_fin(fin1)
  );

  logic       sel = 1'b0;
  logic       line_s, act_s, fin_s, listo_s;
  logic [7:0] cod_s, env_s;
  assign line_s  = sel ? tx1 : tx0;
  assign act_s   = sel ? act1 : act0;
  assign fin_s   = sel ? fin1 : fin0;
  assign listo_s = sel ? bus1.listo_out : bus0.listo_out;
  assign cod_s   = sel ? cod1 : cod0;
  assign env_s   = sel ? env1 : env0;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Receive-side syndrome and overall parity of a word.
  function automatic logic [2:0] sindrome(input logic [7:0] w);
    return {w[3] ^ w[4] ^ w[5] ^ w[6],
            w[1] ^ w[2] ^ w[5] ^ w[6],
            w[0] ^ w[2] ^ w[4] ^ w[6]};
  endfunction

  task automatic send(input logic [3:0] d, input logic [7:0] m);
    @(negedge clk);
    check("listo_pre", listo_s, 1);
    if (sel) begin
      bus1.datos_in = d; bus1.mascara_error = m; bus1.valido_in = 1'b1;
    end else begin
      bus0.datos_in = d; bus0.mascara_error = m; bus0.valido_in = 1'b1;
    end
    @(posedge clk);
    #1;
    bus0.valido_in = 1'b0;
    bus1.valido_in = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] word, input int n);
    logic [9:0] frame;
    frame = {1'b1, word, 1'b0};
    for (int j = 0; j < 10 * n; j++) begin
      @(negedge clk);
      check($sformatf("line[%0d]", j), line_s, frame[j / n]);
      check("fin_low", fin_s, 0);
      check("activo", act_s, 1);
      check("listo_busy", listo_s, 0);
    end
    @(negedge clk);
    check("fin_pulse", fin_s, 1);
    check("listo_fin", listo_s, 1);
    check("activo_end", act_s, 0);
    check("line_idle", line_s, 1);
  endtask

  task automatic wait_fin(input int budget, output int cnt);
    cnt = 0;
    while (cnt < budget) begin
      @(negedge clk);
      cnt++;
      if (fin_s) return;
    end
    check("fin_timeout", 0, 1);
  endtask

  initial begin
    int c;
    bus0.datos_in = '0; bus0.mascara_error = '0; bus0.valido_in = 1'b0;
    bus1.datos_in = '0; bus1.mascara_error = '0; bus1.valido_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_tx", tx0, 1);
    check("rst_listo", bus0.listo_out, 1);
    check("rst_activo", act0, 0);
    check("rst_fin", fin0, 0);
    check("rst_cod", cod0, 8'h00);
    check("rst_env", env0, 8'h00);

    send(4'b1011, 8'h00);
    check("cod_b", cod0, 8'h55);
    check("env_b", env0, 8'h55);
    run_frame(8'h55, 4);
    check("cod_hold", cod0, 8'h55);

    send(4'h0, 8'h00);
    check("cod_0", cod0, 8'h00);
    check("syn_0", sindrome(env0), 0);
    check("par_0", ^env0, 0);
    wait_fin(60, c);
    check("len_0", c, 41);
    send(4'hF, 8'h00);
    check("cod_f", cod0, 8'hFF);
    check("syn_f", sindrome(env0), 0);
    check("par_f", ^env0, 0);
    wait_fin(60, c);
    send(4'h1, 8'h00);
    check("cod_1", cod0, 8'h87);
    check("syn_1", sindrome(env0), 0);
    check("par_1", ^env0, 0);
    run_frame(8'h87, 4);

    send(4'b1011, 8'h01);
    check("cod_m1", cod0, 8'h55);
    check("env_m1", env0, 8'h54);
    check("syn_m1", sindrome(env0), 3'b001);
    check("dbl_m1", (sindrome(env0) != 0) && !(^env0), 0);
    run_frame(8'h54, 4);
    send(4'b1011, 8'h03);
    check("env_m3", env0, 8'h56);
    check("dbl_m3", (sindrome(env0) != 0) && !(^env0), 1);
    wait_fin(60, c);

    // Back-to-back: valid held high across both frames.
    @(negedge clk);
    bus0.datos_in = 4'h1; bus0.mascara_error = 8'h00; bus0.valido_in = 1'b1;
    @(posedge clk);
    #1;
    bus0.datos_in = 4'hF;
    run_frame(8'h87, 4);
    @(negedge clk);
    bus0.valido_in = 1'b0;
    check("b2b_start", tx0, 0);
    check("b2b_listo", bus0.listo_out, 0);
    check("b2b_cod", cod0, 8'hFF);
    wait_fin(60, c);
    check("b2b_len", c, 40);

    // Reset in the middle of a frame.
    send(4'b1011, 8'h00);
    repeat (15) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mr_tx", tx0, 1);
    check("mr_listo", bus0.listo_out, 1);
    check("mr_activo", act0, 0);
    check("mr_fin", fin0, 0);
    check("mr_env", env0, 8'h00);
    @(negedge clk);
    check("mr_fin2", fin0, 0);
    check("mr_tx2", tx0, 1);
    send(4'b1011, 8'h00);
    run_frame(8'h55, 4);

    // One cycle per bit.
    sel = 1'b1;
    send(4'hF, 8'h00);
    check("c1_cod", cod1, 8'hFF);
    run_frame(8'hFF, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

endmodule
